// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS countdown timer driven by the shared 1 Hz enable.
// Loads a sanitised preset, counts down one second per TICK, and on reaching
// 00:00 raises DONE and holds ALARM high for ALARM_LEN ticks.
module countdown_timer #(
    parameter int unsigned ALARM_LEN = 10
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       TICK,
    input  logic       LD,
    input  logic [7:0] LD_MIN,
    input  logic [7:0] LD_SEC,
    input  logic       START,
    input  logic       PAUSE,
    output logic [7:0] MIN,
    output logic [7:0] SEC,
    output logic       RUNNING,
    output logic       DONE,
    output logic       ALARM
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StPaused = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [7:0] AlarmLen = 8'(ALARM_LEN);

    logic [1:0] state_q, state_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       alarm_q, alarm_d;
    logic [7:0] alarm_cnt_q, alarm_cnt_d;
    logic       running_q, running_d;
    logic       done_q, done_d;

    logic [7:0]  load_min;
    logic [7:0]  load_sec;
    logic [15:0] dec_val;
    logic        is_zero;
    logic [7:0]  alarm_cnt_inc;

    // Clamp one BCD byte: tens digit to 5, units digit to 9.
    function automatic logic [7:0] sanitise(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
        units = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {tens, units};
    endfunction

    // One-second BCD decrement of {MM, SS}; saturates at 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mu, st, su;
        logic       borrow;
        {mt, mu, st, su} = v;
        if (v == 16'h0000) begin
            return 16'h0000;
        end
        borrow = 1'b0;
        if (su == 4'd0) begin
            su     = 4'd9;
            borrow = 1'b1;
        end else begin
            su = su - 4'd1;
        end
        if (borrow) begin
            if (st == 4'd0) begin
                st     = 4'd5;
                borrow = 1'b1;
            end else begin
                st     = st - 4'd1;
                borrow = 1'b0;
            end
        end
        if (borrow) begin
            if (mu == 4'd0) begin
                mu     = 4'd9;
                borrow = 1'b1;
            end else begin
                mu     = mu - 4'd1;
                borrow = 1'b0;
            end
        end
        if (borrow) begin
            mt = mt - 4'd1;
        end
        return {mt, mu, st, su};
    endfunction

    // Datapath helpers: sanitised preset, decremented value, zero detect.
    always_comb begin
        load_min      = sanitise(LD_MIN);
        load_sec      = sanitise(LD_SEC);
        dec_val       = bcd_dec({min_q, sec_q});
        is_zero       = ({min_q, sec_q} == 16'h0000);
        alarm_cnt_inc = alarm_cnt_q + 8'd1;
    end

    // Next-state logic: command decoding with the per-state priority rules.
    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        sec_d       = sec_q;
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;

        case (state_q)
            StIdle: begin
                if (LD) begin
                    min_d = load_min;
                    sec_d = load_sec;
                end else if (START && !is_zero) begin
                    state_d = StRun;
                end
            end

            StRun: begin
                // PAUSE suppresses both the decrement and any START.
                if (PAUSE) begin
                    state_d = StPaused;
                end else if (TICK) begin
                    min_d = dec_val[15:8];
                    sec_d = dec_val[7:0];
                    if (dec_val == 16'h0000) begin
                        state_d     = StDone;
                        alarm_d     = 1'b1;
                        alarm_cnt_d = 8'd0;
                    end
                end
            end

            StPaused: begin
                if (LD) begin
                    min_d   = load_min;
                    sec_d   = load_sec;
                    state_d = StIdle;
                end else if (START) begin
                    state_d = StRun;
                end
            end

            StDone: begin
                if (LD) begin
                    min_d       = load_min;
                    sec_d       = load_sec;
                    alarm_d     = 1'b0;
                    alarm_cnt_d = 8'd0;
                    state_d     = StIdle;
                end else if (START) begin
                    alarm_d     = 1'b0;
                    alarm_cnt_d = 8'd0;
                    state_d     = StIdle;
                end else if (TICK && alarm_q) begin
                    // Count stops once the alarm has timed out.
                    alarm_cnt_d = alarm_cnt_inc;
                    if (alarm_cnt_inc >= AlarmLen) begin
                        alarm_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status flags decoded from the next state so they stay registered.
    always_comb begin
        running_d = (state_d == StRun);
        done_d    = (state_d == StDone);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q     <= StIdle;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= 8'd0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    assign MIN     = min_q;
    assign SEC     = sec_q;
    assign RUNNING = running_q;
    assign DONE    = done_q;
    assign ALARM   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with ALARM_LEN=3.
`timescale 1ns / 1ps
module tb_countdown_timer;

    logic       cp;
    logic       cr;
    logic       tick;
    logic       ld;
    logic [7:0] ld_min;
    logic [7:0] ld_sec;
    logic       start;
    logic       pause;
    logic [7:0] min;
    logic [7:0] sec;
    logic       running;
    logic       done;
    logic       alarm;

    int checks = 0;
    int errors = 0;

    countdown_timer #(
        .ALARM_LEN(3)
    ) dut (
        .CP      (cp),
        .CR      (cr),
        .TICK    (tick),
        .LD      (ld),
        .LD_MIN  (ld_min),
        .LD_SEC  (ld_sec),
        .START   (start),
        .PAUSE   (pause),
        .MIN     (min),
        .SEC     (sec),
        .RUNNING (running),
        .DONE    (done),
        .ALARM   (alarm)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    // Compare {MIN, SEC, RUNNING, DONE, ALARM} against expectation.
    task automatic check(input string tag, input logic [7:0] e_min, input logic [7:0] e_sec,
                         input logic e_run, input logic e_done, input logic e_alarm);
        logic [18:0] obs;
        logic [18:0] exp;
        obs = {min, sec, running, done, alarm};
        exp = {e_min, e_sec, e_run, e_done, e_alarm};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed MIN=%h SEC=%h RUN=%b DONE=%b ALARM=%b, expected MIN=%h SEC=%h RUN=%b DONE=%b ALARM=%b",
                   tag, obs[18:11], obs[10:3], obs[2], obs[1], obs[0],
                   exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Advance one clock edge, then drop all strobes; sampling is 1 ns after the edge.
    task automatic step();
        @(posedge cp);
        #1;
        tick  = 1'b0;
        ld    = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        ld     = 1'b1;
        ld_min = m;
        ld_sec = s;
        step();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step();
    endtask

    initial begin
        cr     = 1'b1;
        tick   = 1'b0;
        ld     = 1'b0;
        ld_min = 8'h00;
        ld_sec = 8'h00;
        start  = 1'b0;
        pause  = 1'b0;
        #2;
        check("reset", 8'h00, 8'h00, 0, 0, 0);
        repeat (2) @(posedge cp);
        #3 cr = 1'b0;

        // Load 01:00, start, one tick.
        do_load(8'h01, 8'h00);
        check("load_0100", 8'h01, 8'h00, 0, 0, 0);
        start = 1'b1;
        tick  = 1'b1;
        step();
        check("start_no_dec", 8'h01, 8'h00, 1, 0, 0);
        do_tick();
        check("tick_0059", 8'h00, 8'h59, 1, 0, 0);
        do_load(8'h10, 8'h00);
        check("ld_ignored_run", 8'h00, 8'h59, 1, 0, 0);
        do_pause();
        check("pause", 8'h00, 8'h59, 0, 0, 0);

        // Full borrow chain 10:00 -> 09:59.
        do_load(8'h10, 8'h00);
        check("paused_ld_idle", 8'h10, 8'h00, 0, 0, 0);
        do_start();
        do_tick();
        check("borrow_0959", 8'h09, 8'h59, 1, 0, 0);
        do_pause();
        do_load(8'h00, 8'h10);
        do_start();
        do_tick();
        check("borrow_0009", 8'h00, 8'h09, 1, 0, 0);

        // Expiry and alarm length.
        do_pause();
        do_load(8'h00, 8'h02);
        do_start();
        do_tick();
        check("exp_0001", 8'h00, 8'h01, 1, 0, 0);
        do_tick();
        check("expire", 8'h00, 8'h00, 0, 1, 1);
        do_tick();
        check("alarm_t1", 8'h00, 8'h00, 0, 1, 1);
        step();
        step();
        check("alarm_idle", 8'h00, 8'h00, 0, 1, 1);
        do_tick();
        check("alarm_t2", 8'h00, 8'h00, 0, 1, 1);
        do_tick();
        check("alarm_off", 8'h00, 8'h00, 0, 1, 0);
        do_tick();
        check("alarm_stays_off", 8'h00, 8'h00, 0, 1, 0);
        do_start();
        check("done_start_idle", 8'h00, 8'h00, 0, 0, 0);
        do_start();
        check("start_at_zero", 8'h00, 8'h00, 0, 0, 0);
        do_tick();
        check("idle_tick_zero", 8'h00, 8'h00, 0, 0, 0);

        // Alarm count must restart after leaving DONE via LD.
        do_load(8'h00, 8'h01);
        do_start();
        do_tick();
        check("expire2", 8'h00, 8'h00, 0, 1, 1);
        do_tick();
        ld     = 1'b1;
        start  = 1'b1;
        ld_min = 8'h00;
        ld_sec = 8'h01;
        step();
        check("done_ld_beats_start", 8'h00, 8'h01, 0, 0, 0);
        do_start();
        do_tick();
        check("expire3", 8'h00, 8'h00, 0, 1, 1);
        do_tick();
        do_tick();
        check("alarm_cnt_cleared", 8'h00, 8'h00, 0, 1, 1);
        do_tick();
        check("alarm_off2", 8'h00, 8'h00, 0, 1, 0);
        do_load(8'h03, 8'h45);
        check("done_ld", 8'h03, 8'h45, 0, 0, 0);

        // Load sanitising.
        do_load(8'h7A, 8'hC9);
        check("sanitise", 8'h59, 8'h59, 0, 0, 0);

        // Pause and priority.
        ld     = 1'b1;
        start  = 1'b1;
        ld_min = 8'h00;
        ld_sec = 8'h30;
        step();
        check("idle_ld_beats_start", 8'h00, 8'h30, 0, 0, 0);
        do_start();
        pause = 1'b1;
        tick  = 1'b1;
        step();
        check("pause_beats_tick", 8'h00, 8'h30, 0, 0, 0);
        do_tick();
        do_tick();
        check("paused_ticks", 8'h00, 8'h30, 0, 0, 0);
        do_start();
        do_tick();
        check("resume_0029", 8'h00, 8'h29, 1, 0, 0);
        start = 1'b1;
        pause = 1'b1;
        step();
        check("pause_beats_start", 8'h00, 8'h29, 0, 0, 0);

        // Async reset mid-count at 05:17.
        do_load(8'h05, 8'h18);
        do_start();
        do_tick();
        check("run_0517", 8'h05, 8'h17, 1, 0, 0);
        #3 cr = 1'b1;
        #1;
        check("async_reset", 8'h00, 8'h00, 0, 0, 0);
        #1 cr = 1'b0;
        do_tick();
        do_tick();
        check("after_reset", 8'h00, 8'h00, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD minutes:seconds countdown timer for the digital clock. Where the clock's counters count up, this block loads a preset MM:SS value and counts it down to 00:00, one step per 1 Hz tick. At 00:00 it flags completion and drives an alarm for a programmable number of ticks. It shares the clock's 1 Hz enable and its BCD display path.

## Interface
Parameters:
- ALARM_LEN, default 10: number of TICK pulses ALARM stays high after expiry (1..255).

Ports:
- CP  input  1  clock; all state changes on its rising edge.
- CR  input  1  asynchronous, active-high reset.
- TICK  input  1  1 Hz enable; high for exactly one CP cycle per second.
- LD  input  1  load strobe; one CP cycle.
- LD_MIN  input  8  preset minutes, BCD {tens, units}.
- LD_SEC  input  8  preset seconds, BCD {tens, units}.
- START  input  1  start/resume/acknowledge strobe; one CP cycle.
- PAUSE  input  1  pause strobe; one CP cycle.
- MIN  output  8  current minutes, BCD.
- SEC  output  8  current seconds, BCD.
- RUNNING  output  1  high in RUN.
- DONE  output  1  high in DONE.
- ALARM  output  1  alarm drive.

## Operation
- All outputs are registered. Reset gives MIN=8'h00, SEC=8'h00, state IDLE, RUNNING=0, DONE=0, ALARM=0, alarm tick count 0. Reset takes effect immediately in any state, including mid-count.
- States are IDLE, RUN, PAUSED and DONE.
- IDLE:
  - LD loads the preset and stays in IDLE.
  - START with MIN:SEC ≠ 00:00 goes to RUN.
  - START at 00:00 is ignored.
  - PAUSE is ignored.
- RUN:
  - On TICK, decrement MIN:SEC by one second.
  - If the new value is 00:00, go to DONE and set ALARM=1.
  - PAUSE goes to PAUSED.
  - LD and START are ignored.
- PAUSED:
  - START goes to RUN.
  - LD loads the preset and goes to IDLE.
  - TICK is ignored.
- DONE:
  - DONE=1 and MIN:SEC holds 00:00.
  - Each TICK increments the alarm count. On the ALARM_LEN-th TICK, ALARM drops to 0; the state stays DONE.
  - START clears ALARM and the count and goes to IDLE.
  - LD clears ALARM and the count, loads the preset and goes to IDLE.
- Load sanitising, per digit:
  - A tens digit >5 loads as 5.
  - A units digit >9 loads as 9.
  - The maximum value is therefore 59:59.
- Decrement uses a BCD borrow chain:
  - Seconds units: 0→9 with borrow, else −1.
  - Seconds tens: on borrow, 0→5 with borrow, else −1.
  - Minutes units: on borrow, 0→9 with borrow, else −1.
  - Minutes tens: on borrow, −1.
  - Never decrement below 00:00.
- Priority for same-cycle events:
  - LD beats START in IDLE and PAUSED; LD and START both high gives a load and IDLE.
  - In RUN, PAUSE beats TICK: no decrement that cycle.
  - In RUN, START and PAUSE together: PAUSE wins.
  - In DONE, LD beats START.

## Timing
- Commands take effect on the first CP edge where the strobe is sampled high. Outputs change one CP edge after the strobe; latency is 1 cycle.
- A START edge moves the state to RUN with no decrement on that edge, even if TICK is also high. The first decrement happens on the next TICK sampled in RUN.
- The edge that decrements to 00:00 also sets DONE=1, ALARM=1 and RUNNING=0.
- ALARM falls on the edge of the ALARM_LEN-th TICK after entering DONE. The TICK on the expiry edge is not counted.
- MIN and SEC are always valid BCD in 00:00..59:59.

## Test plan
- Load, start, single tick: LD with LD_MIN=8'h01, LD_SEC=8'h00; then START; then 1 TICK -> MIN=8'h00, SEC=8'h59, RUNNING=1.
- Full borrow chain: load 10:00, start, 1 TICK -> 09:59. Load 00:10, start, 1 TICK -> 00:09.
- Expiry and alarm length (ALARM_LEN=3): load 00:02, start, 2 TICKs -> 00:00, DONE=1, ALARM=1. Then 3 more TICKs -> ALARM=0 on the third, DONE=1. Then START -> IDLE, DONE=0.
- Load sanitising: LD_MIN=8'h7A, LD_SEC=8'hC9 -> MIN=8'h59, SEC=8'h59.
- Pause and priority:
  - In RUN at 00:30, PAUSE and TICK in the same cycle -> PAUSED, value stays 00:30.
  - Further TICKs leave the value at 00:30.
  - START, then 1 TICK -> 00:29.
  - START at 00:00 in IDLE -> stays IDLE.
- Async reset mid-count: in RUN at 05:17, assert CR between edges -> immediately MIN=SEC=8'h00, RUNNING=DONE=ALARM=0. After release, TICKs leave the value at 00:00.
